// File: rtl/odd_parity_checker_pkg.sv
// Shared definitions for the odd-parity checker: default sizes and the
// parity-error rule (XNOR reduction over the data word and its parity bit).
package odd_parity_pkg;

    // Default data word width and error counter width.
    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    // Widest {in, p} vector the helper function accepts. Narrower vectors are
    // zero-extended, which leaves the XOR reduction unchanged.
    localparam int PARITY_FN_MAX_BITS = 65;

    // Odd-parity violation: total number of ones over {in, p} is even.
    function automatic logic parity_error(input logic [PARITY_FN_MAX_BITS-1:0] bits);
        return ~(^bits);
    endfunction

endpackage

// File: rtl/odd_parity_checker_parity_tree.sv
// Balanced combinational XOR reduction over N_BITS inputs. The input vector is
// zero-padded up to the next power of two and folded pairwise, one tree level
// per loop pass, so the logic depth grows with log2(N_BITS).
module parity_tree #(
    parameter int N_BITS = 5
) (
    input  logic [N_BITS-1:0] bits,
    output logic              xor_out
);

    localparam int LEVELS = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int LEAVES = 1 << LEVELS;

    // Working storage for the tree; level k occupies the low LEAVES>>k entries.
    logic [LEAVES-1:0] work;

    // Fold adjacent pairs level by level until a single bit remains.
    always_comb begin
        work = '0;
        work[N_BITS-1:0] = bits;
        for (int s = LEAVES / 2; s >= 1; s = s / 2) begin
            for (int i = 0; i < s; i++) begin
                work[i] = work[2*i] ^ work[2*i+1];
            end
        end
        xor_out = work[0];
    end

endmodule

// File: rtl/odd_parity_checker.sv
// Receive-side odd-parity checker. Each valid beat of {in, p} is checked for
// odd total parity; the per-beat result is registered (1-cycle latency), and a
// sticky error flag plus a saturating error counter are kept for status.
//
// Handshake: in_valid qualifies in/p in the cycle it is high; there is no
// ready, every cycle can carry a new beat. out_valid/error describe the beat
// sampled on the previous rising edge; when that beat was not valid both are 0.
module odd_parity_checker
    import odd_parity_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic             p,
    input  logic             clr,
    output logic             out_valid,
    output logic             error,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             tree_xor;
    logic             beat_err;
    logic             count_event;

    logic             out_valid_q;
    logic             error_q;
    logic             err_sticky_q;
    logic [CNT_W-1:0] err_count_q;

    // XOR of all data bits and the parity bit.
    parity_tree #(
        .N_BITS (WIDTH + 1)
    ) u_parity_tree (
        .bits    ({in, p}),
        .xor_out (tree_xor)
    );

    // An even total (tree XOR of 0) is an odd-parity violation.
    always_comb begin
        beat_err    = parity_error({{(PARITY_FN_MAX_BITS-1){1'b0}}, tree_xor});
        count_event = in_valid & beat_err;
    end

    // Per-beat result register; invalid beats produce out_valid=0, error=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            error_q     <= count_event;
        end
    end

    // Status: clr beats a same-cycle error, and the counter sticks at its max.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else if (clr) begin
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else if (count_event) begin
            err_sticky_q <= 1'b1;
            if (err_count_q != CNT_MAX) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        out_valid  = out_valid_q;
        error      = error_q;
        err_sticky = err_sticky_q;
        err_count  = err_count_q;
    end

endmodule

// File: tb/tb_odd_parity_checker.sv
// Directed bench for odd_parity_checker. A default instance (CNT_W=8) carries
// most checks; a CNT_W=2 instance driven by the same inputs shows saturation.
module tb_odd_parity_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_d;
    logic       p;
    logic       clr;

    logic       ov;
    logic       er;
    logic       st;
    logic [7:0] cnt;

    logic       ov2;
    logic       er2;
    logic       st2;
    logic [1:0] cnt2;

    int vectors;
    int miscompares;

    odd_parity_checker #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in         (in_d),
        .p          (p),
        .clr        (clr),
        .out_valid  (ov),
        .error      (er),
        .err_sticky (st),
        .err_count  (cnt)
    );

    odd_parity_checker #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in         (in_d),
        .p          (p),
        .clr        (clr),
        .out_valid  (ov2),
        .error      (er2),
        .err_sticky (st2),
        .err_count  (cnt2)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic pb, input logic c);
        in_valid = v;
        in_d     = d;
        p        = pb;
        clr      = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 4'b0101, 1'b0, 1'b0);
        tick();
        tick();
        vectors++;
        if (ov !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", ov); end
        vectors++;
        if (er !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", er); end
        vectors++;
        if (st !== 1'b0) begin miscompares++; $display("FAIL reset_sticky: got %b want 0", st); end
        vectors++;
        if (cnt !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", cnt); end
        vectors++;
        if (cnt2 !== 2'd0) begin miscompares++; $display("FAIL reset_count_sat: got %0d want 0", cnt2); end
        rst_n = 1'b1;
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_sweep();
        logic [3:0] d_tab [4] = '{4'b0101, 4'b1101, 4'b0111, 4'b1001};
        logic       p_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       e_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] c_tab [4] = '{8'd1, 8'd2, 8'd2, 8'd2};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, d_tab[i], p_tab[i], 1'b0);
            tick();
            vectors++;
            if (ov !== 1'b1) begin miscompares++; $display("FAIL sweep_valid[%0d]: got %b want 1", i, ov); end
            vectors++;
            if (er !== e_tab[i]) begin miscompares++; $display("FAIL sweep_error[%0d]: got %b want %b", i, er, e_tab[i]); end
            vectors++;
            if (cnt !== c_tab[i]) begin miscompares++; $display("FAIL sweep_count[%0d]: got %0d want %0d", i, cnt, c_tab[i]); end
        end
        vectors++;
        if (st !== 1'b1) begin miscompares++; $display("FAIL sweep_sticky: got %b want 1", st); end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0000, 1'b0, 1'b0);
            tick();
            vectors++;
            if (ov !== 1'b0) begin miscompares++; $display("FAIL gap_valid[%0d]: got %b want 0", i, ov); end
            vectors++;
            if (er !== 1'b0) begin miscompares++; $display("FAIL gap_error[%0d]: got %b want 0", i, er); end
            vectors++;
            if (cnt !== 8'd2) begin miscompares++; $display("FAIL gap_count[%0d]: got %0d want 2", i, cnt); end
            // Good beat between gaps: 0111/0 has three ones plus p=0, odd.
            drive(1'b1, 4'b0111, 1'b0, 1'b0);
            tick();
            vectors++;
            if (ov !== 1'b1 || er !== 1'b0) begin
                miscompares++; $display("FAIL gap_good[%0d]: got v=%b e=%b want v=1 e=0", i, ov, er);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] s_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        tick();
        vectors++;
        if (cnt !== 8'd0 || cnt2 !== 2'd0 || st !== 1'b0) begin
            miscompares++; $display("FAIL sat_clear: got cnt=%0d cnt2=%0d st=%b want 0 0 0", cnt, cnt2, st);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0000, 1'b0, 1'b0);
            tick();
            vectors++;
            if (cnt2 !== s_tab[i]) begin miscompares++; $display("FAIL sat_count2[%0d]: got %0d want %0d", i, cnt2, s_tab[i]); end
            vectors++;
            if (cnt !== 8'(i + 1)) begin miscompares++; $display("FAIL sat_count8[%0d]: got %0d want %0d", i, cnt, i + 1); end
        end
        vectors++;
        if (st2 !== 1'b1 || er2 !== 1'b1) begin miscompares++; $display("FAIL sat_sticky: got st=%b e=%b want 1 1", st2, er2); end
    endtask

    task automatic test_clr_collision();
        drive(1'b1, 4'b0101, 1'b0, 1'b1);
        tick();
        vectors++;
        if (er !== 1'b1 || ov !== 1'b1) begin miscompares++; $display("FAIL clr_error: got v=%b e=%b want 1 1", ov, er); end
        vectors++;
        if (cnt !== 8'd0) begin miscompares++; $display("FAIL clr_count: got %0d want 0", cnt); end
        vectors++;
        if (st !== 1'b0) begin miscompares++; $display("FAIL clr_sticky: got %b want 0", st); end
        drive(1'b1, 4'b1101, 1'b1, 1'b0);
        tick();
        vectors++;
        if (cnt !== 8'd1 || st !== 1'b1) begin miscompares++; $display("FAIL clr_next: got cnt=%0d st=%b want 1 1", cnt, st); end
    endtask

    task automatic test_exhaustive();
        logic       exp_e;
        logic [7:0] exp_c;
        logic [4:0] v5;
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        tick();
        exp_c = 8'd0;
        for (int v = 0; v < 32; v++) begin
            v5 = 5'(v);
            drive(1'b1, v5[4:1], v5[0], 1'b0);
            exp_e = ((($countones(v5[4:1]) + int'(v5[0])) % 2) == 0);
            if (exp_e) exp_c = exp_c + 8'd1;
            tick();
            vectors++;
            if (er !== exp_e || ov !== 1'b1) begin
                miscompares++; $display("FAIL exh[%0d]: in=%b p=%b got e=%b v=%b want e=%b v=1", v, v5[4:1], v5[0], er, ov, exp_e);
            end
        end
        vectors++;
        if (cnt !== exp_c) begin miscompares++; $display("FAIL exh_count: got %0d want %0d", cnt, exp_c); end
    endtask

    task automatic test_reset_midstream();
        rst_n = 1'b0;
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        vectors++;
        if (ov !== 1'b0 || er !== 1'b0 || cnt !== 8'd0 || st !== 1'b0) begin
            miscompares++; $display("FAIL midrst_state: got v=%b e=%b cnt=%0d st=%b want 0 0 0 0", ov, er, cnt, st);
        end
        rst_n = 1'b1;
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        vectors++;
        if (ov !== 1'b0 || er !== 1'b0 || cnt !== 8'd0) begin
            miscompares++; $display("FAIL midrst_dropped: got v=%b e=%b cnt=%0d want 0 0 0", ov, er, cnt);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        #1;
        test_reset();
        test_sweep();
        test_gaps();
        test_saturation();
        test_clr_collision();
        test_exhaustive();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/odd_parity_checker.md
# odd_parity_checker

Registered odd-parity checker for a parallel data word plus its parity bit. Each valid input beat is checked for odd total parity over data and parity bit. The block reports a per-beat error flag one cycle later and keeps a sticky error flag and a saturating error counter for status readout. It sits on the receive side of a link, after the odd-parity generator on the transmit side.

## Interface
Parameters:
- WIDTH, 4, data word width in bits (≥1)
- CNT_W, 8, width of the error counter (≥1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  current beat of in/p is to be checked
- in  input  WIDTH  data word
- p  input  1  received parity bit (odd-parity convention)
- clr  input  1  synchronous clear of err_sticky and err_count
- out_valid  output  1  error is valid this cycle
- error  output  1  1 = parity violation on the checked beat
- err_sticky  output  1  set by any error, held until clr or reset
- err_count  output  CNT_W  number of errored beats, saturating

## Operation
- Parity rule: total = popcount(in) + p. Beat is good if total is odd. error = NOT(XOR-reduce(in) XOR p).
- Examples with WIDTH=4: in=0101,p=0 → error=1; in=1101,p=1 → error=1; in=0111,p=0 → error=0; in=1001,p=1 → error=0.
- When in_valid=0, error and out_valid go to 0 next cycle. in/p are ignored and counters hold.
- err_sticky: set when a valid errored beat is checked; otherwise holds.
- err_count: +1 per valid errored beat; saturates at 2^CNT_W−1 with no wrap.
- clr=1 clears err_sticky and err_count. clr has priority over a simultaneous error update: the result is 0, and that beat's error is not counted. clr does not affect error or out_valid.
- No back-pressure: a new beat is accepted every cycle.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on error/out_valid after edge N, and are valid during cycle N+1.
- err_sticky and err_count update on the same edge as error.
- Reset (rst_n=0 at a rising edge): out_valid=0, error=0, err_sticky=0, err_count=0. Reset overrides in_valid and clr.
- Reset mid-stream: a beat sampled while rst_n=0 is dropped and produces no output.
- Back-to-back valid beats: one result per cycle, in order.

## Structure
- Shared package odd_parity_pkg: default WIDTH/CNT_W localparams and a function for the parity-error computation (XNOR reduction of {in, p}).
- One natural sub-module, parity_tree: a combinational XOR reduction over WIDTH+1 bits, balanced for large WIDTH.
- Top level holds the output register, the sticky flag and the saturating counter.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and in=0101,p=0 → out_valid=0, error=0, err_sticky=0, err_count=0.
- Vector sweep, one beat per cycle: 0101/0, 1101/1, 0111/0, 1001/1 → error = 1,1,0,0 one cycle after each beat. err_count=2 and err_sticky=1 after the last beat.
- Gaps: in_valid=0 between beats with in=0000,p=0 (would be an error) → out_valid=0, error=0, err_count unchanged.
- Saturation with CNT_W=2: five errored beats → err_count sequence 1,2,3,3,3.
- clr with a simultaneous errored beat → error=1 that cycle, but err_count=0 and err_sticky=0 afterwards. The next errored beat gives err_count=1.
- Exhaustive WIDTH=4: all 32 in/p combinations → error=1 exactly when popcount(in)+p is even.
